// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port byte RAM; data port has priority.
// Optional one-word fetch buffer enabled by defining FETCH_BUFFER_EN.
module mem_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din
);

    // state | meaning
    // IDLE  | waiting for a request; grant happens at the edge leaving IDLE
    // READ  | address phase (cnt < n) then one extra cycle to catch the last byte
    // WRITE | one RAM write per byte, cnt = byte index
    // DONE  | one-cycle ready pulse to the owner
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic [2:0]  nbytes;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  len_q;
    logic        owner_if;
    logic [31:0] rbuf;
    logic [31:0] rd_word;
    logic [31:0] rd_final;
    logic        fetch_hit;

`ifdef FETCH_BUFFER_EN
    logic        we_q;
    logic        buf_valid;
    logic [31:0] buf_addr;
    logic [31:0] buf_word;
    logic        wr_hit;

    assign fetch_hit = buf_valid && (buf_addr == if_addr);

    // Modulo-2^32 distance from the buffered base catches wrap-around overlaps.
    always_comb begin
        wr_hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if ((3'(k) < nbytes) && ((addr_q + 32'(k) - buf_addr) < 32'd4))
                wr_hit = 1'b1;
        end
    end
`else
    assign fetch_hit = 1'b0;
`endif

    always_comb begin
        case (len_q)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    // Byte cnt-1 arrives on ram_din this cycle; merge it before it is registered.
    always_comb begin
        rd_word = rbuf;
        case (cnt)
            3'd1:    rd_word[7:0]   = ram_din;
            3'd2:    rd_word[15:8]  = ram_din;
            3'd3:    rd_word[23:16] = ram_din;
            3'd4:    rd_word[31:24] = ram_din;
            default: rd_word = rbuf;
        endcase
        case (len_q)
            2'b00:   rd_final = rd_word & 32'h0000_00FF;
            2'b01:   rd_final = rd_word & 32'h0000_FFFF;
            default: rd_final = rd_word;
        endcase
    end

    always_comb begin
        state_nxt = state;
        ram_addr  = 32'd0;
        ram_we    = 1'b0;
        ram_dout  = 8'd0;
        if_ready  = 1'b0;
        mem_ready = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req)
                    state_nxt = mem_we ? WRITE : READ;
                else if (if_req)
                    state_nxt = fetch_hit ? DONE : READ;
            end
            READ: begin
                if (cnt < nbytes)
                    ram_addr = addr_q + {29'd0, cnt};
                if (cnt == nbytes)
                    state_nxt = DONE;
            end
            WRITE: begin
                ram_we   = 1'b1;
                ram_addr = addr_q + {29'd0, cnt};
                case (cnt)
                    3'd0:    ram_dout = wdata_q[7:0];
                    3'd1:    ram_dout = wdata_q[15:8];
                    3'd2:    ram_dout = wdata_q[23:16];
                    default: ram_dout = wdata_q[31:24];
                endcase
                if (cnt == nbytes - 3'd1)
                    state_nxt = DONE;
            end
            DONE: begin
                if_ready  = owner_if;
                mem_ready = !owner_if;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            len_q     <= 2'b11;
            owner_if  <= 1'b0;
            rbuf      <= 32'd0;
            if_data   <= 32'd0;
            mem_rdata <= 32'd0;
`ifdef FETCH_BUFFER_EN
            we_q      <= 1'b0;
            buf_valid <= 1'b0;
            buf_addr  <= 32'd0;
            buf_word  <= 32'd0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (mem_req || if_req) begin
                        cnt      <= 3'd0;
                        rbuf     <= 32'd0;
                        owner_if <= !mem_req;
                        if (mem_req) begin
                            addr_q  <= mem_addr;
                            len_q   <= mem_len;
                            wdata_q <= mem_wdata;
`ifdef FETCH_BUFFER_EN
                            we_q    <= mem_we;
`endif
                        end else begin
                            addr_q  <= if_addr;
                            len_q   <= 2'b11;
                            wdata_q <= 32'd0;
`ifdef FETCH_BUFFER_EN
                            we_q    <= 1'b0;
                            if (fetch_hit)
                                if_data <= buf_word;
`endif
                        end
                    end
                end
                READ: begin
                    cnt  <= cnt + 3'd1;
                    rbuf <= rd_word;
                    if (cnt == nbytes) begin
                        if (owner_if) begin
                            if_data <= rd_final;
`ifdef FETCH_BUFFER_EN
                            buf_valid <= 1'b1;
                            buf_addr  <= addr_q;
                            buf_word  <= rd_final;
`endif
                        end else begin
                            mem_rdata <= rd_final;
                        end
                    end
                end
                WRITE: cnt <= cnt + 3'd1;
                DONE: begin
`ifdef FETCH_BUFFER_EN
                    if (!owner_if && we_q && wr_hit)
                        buf_valid <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte RAM (one-cycle read latency).
// Covers both builds; buffer-specific expectations follow FETCH_BUFFER_EN.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_ready;
    logic [31:0] if_data;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [1:0]  mem_len = 2'b00;
    logic [31:0] mem_wdata = 32'd0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    logic [7:0]  ram [0:4095];
    int          n_assert = 0;
    int          n_fail = 0;
    logic [7:0]  exp_b [4];

    mem_arbiter dut (
        .clock    (clock),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_data  (if_data),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_len  (mem_len),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .ram_din  (ram_din)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        ram_din <= ram[ram_addr[11:0]];
        if (ram_we)
            ram[ram_addr[11:0]] <= ram_dout;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        chk("ready_exclusive", 32'(if_ready & mem_ready), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'h104] = 8'h01; ram[12'h105] = 8'h02; ram[12'h106] = 8'h03; ram[12'h107] = 8'h04;
        ram[12'h200] = 8'h5A; ram[12'h201] = 8'hA5;
        ram[12'hFFE] = 8'h34; ram[12'hFFF] = 8'h80; ram[12'h000] = 8'h56; ram[12'h001] = 8'h78;

        // reset state
        tick(); tick();
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_dout", 32'(ram_dout), 32'd0);
        reset = 1'b1;
        tick();

        // 4B fetch at 0x100; inputs changed after grant must be ignored
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("fetch_ram_addr", ram_addr, 32'h100 + 32'(k));
            chk("fetch_ram_we", 32'(ram_we), 32'd0);
            if (k == 0) begin if_req = 1'b0; if_addr = 32'h200; end
            tick();
        end
        chk("fetch_c5_ready", 32'(if_ready), 32'd0);
        chk("fetch_c5_addr", ram_addr, 32'd0);
        tick();
        chk("fetch_c6_ready", 32'(if_ready), 32'd1);
        chk("fetch_c6_data", if_data, 32'h4433_2211);
        tick();
        chk("fetch_dead_ready", 32'(if_ready), 32'd0);

        // simultaneous requests: data 2B read first, then fetch of 0x104
        if_req = 1'b1; if_addr = 32'h104;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b01; mem_addr = 32'h200;
        tick();
        chk("prio_c1_addr", ram_addr, 32'h200);
        mem_req = 1'b0;
        tick();
        chk("prio_c2_addr", ram_addr, 32'h201);
        tick();
        chk("prio_c3_addr", ram_addr, 32'd0);
        chk("prio_c3_mready", 32'(mem_ready), 32'd0);
        tick();
        chk("prio_c4_mready", 32'(mem_ready), 32'd1);
        chk("prio_c4_iready", 32'(if_ready), 32'd0);
        chk("prio_c4_rdata", mem_rdata, 32'h0000_A55A);
        tick();
        chk("prio_dead_addr", ram_addr, 32'd0);
        chk("prio_dead_mready", 32'(mem_ready), 32'd0);
        chk("prio_dead_iready", 32'(if_ready), 32'd0);
        tick();
        chk("prio_fetch_c1_addr", ram_addr, 32'h104);
        if_req = 1'b0;
        repeat (5) tick();
        chk("prio_fetch_ready", 32'(if_ready), 32'd1);
        chk("prio_fetch_data", if_data, 32'h0403_0201);
        chk("prio_fetch_mready", 32'(mem_ready), 32'd0);
        tick();

        // 4B write of 0xDEADBEEF to 0x10
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b11; mem_addr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("wr_ram_we", 32'(ram_we), 32'd1);
            chk("wr_ram_addr", ram_addr, 32'h10 + 32'(k));
            chk("wr_ram_dout", 32'(ram_dout), 32'(exp_b[k]));
            chk("wr_mready_early", 32'(mem_ready), 32'd0);
            if (k == 0) begin mem_req = 1'b0; mem_wdata = 32'd0; end
            tick();
        end
        chk("wr_c5_mready", 32'(mem_ready), 32'd1);
        chk("wr_c5_we", 32'(ram_we), 32'd0);
        chk("wr_c5_addr", ram_addr, 32'd0);
        chk("wr_ram_content", {ram[12'h013], ram[12'h012], ram[12'h011], ram[12'h010]}, 32'hDEAD_BEEF);
        tick();
        chk("wr_idle_mready", 32'(mem_ready), 32'd0);

        // 1B read at 0xFFFFFFFF, zero-extended
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'hFFFF_FFFF;
        tick();
        chk("b1_c1_addr", ram_addr, 32'hFFFF_FFFF);
        mem_req = 1'b0;
        tick();
        chk("b1_c2_mready", 32'(mem_ready), 32'd0);
        tick();
        chk("b1_c3_mready", 32'(mem_ready), 32'd1);
        chk("b1_c3_rdata", mem_rdata, 32'h0000_0080);
        tick();

        // len=10 treated as 4B; address wraps past 0xFFFFFFFF
        mem_req = 1'b1; mem_len = 2'b10; mem_addr = 32'hFFFF_FFFE;
        tick();
        chk("wrap_c1_addr", ram_addr, 32'hFFFF_FFFE);
        mem_req = 1'b0;
        tick();
        chk("wrap_c2_addr", ram_addr, 32'hFFFF_FFFF);
        tick();
        chk("wrap_c3_addr", ram_addr, 32'h0000_0000);
        tick();
        chk("wrap_c4_addr", ram_addr, 32'h0000_0001);
        tick();
        chk("wrap_c5_mready", 32'(mem_ready), 32'd0);
        tick();
        chk("wrap_c6_mready", 32'(mem_ready), 32'd1);
        chk("wrap_c6_rdata", mem_rdata, 32'h7856_8034);
        chk("if_data_held", if_data, 32'h0403_0201);
        tick();

        // reset during C3 of a write aborts it
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b11; mem_addr = 32'h20; mem_wdata = 32'h1122_3344;
        tick();
        mem_req = 1'b0;
        tick();
        tick();
        chk("abort_c3_we", 32'(ram_we), 32'd1);
        chk("abort_c3_addr", ram_addr, 32'h22);
        chk("abort_c3_dout", 32'(ram_dout), 32'h22);
        reset = 1'b0;
        tick();
        chk("abort_we", 32'(ram_we), 32'd0);
        chk("abort_addr", ram_addr, 32'd0);
        chk("abort_mready", 32'(mem_ready), 32'd0);
        chk("abort_mem_rdata", mem_rdata, 32'd0);
        chk("abort_if_data", if_data, 32'd0);
        reset = 1'b1;
        repeat (4) begin
            tick();
            chk("abort_no_mready", 32'(mem_ready), 32'd0);
            chk("abort_no_we", 32'(ram_we), 32'd0);
        end

        // fetch, refetch (buffer hit when enabled), overlapping write, refetch
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("buf_fill_addr", ram_addr, 32'h100);
        if_req = 1'b0;
        repeat (5) tick();
        chk("buf_fill_ready", 32'(if_ready), 32'd1);
        chk("buf_fill_data", if_data, 32'h4433_2211);
        tick();
        if_req = 1'b1;
        tick();
`ifdef FETCH_BUFFER_EN
        chk("buf_hit_ready", 32'(if_ready), 32'd1);
        chk("buf_hit_addr", ram_addr, 32'd0);
        chk("buf_hit_data", if_data, 32'h4433_2211);
        if_req = 1'b0;
        tick();
        chk("buf_hit_idle", 32'(if_ready), 32'd0);
`else
        chk("nobuf_addr", ram_addr, 32'h100);
        chk("nobuf_ready", 32'(if_ready), 32'd0);
        if_req = 1'b0;
        repeat (5) tick();
        chk("nobuf_c6_ready", 32'(if_ready), 32'd1);
        tick();
`endif
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b00; mem_addr = 32'h102; mem_wdata = 32'h0000_0099;
        tick();
        chk("inv_wr_we", 32'(ram_we), 32'd1);
        chk("inv_wr_addr", ram_addr, 32'h102);
        chk("inv_wr_dout", 32'(ram_dout), 32'h99);
        mem_req = 1'b0;
        tick();
        chk("inv_wr_mready", 32'(mem_ready), 32'd1);
        tick();
        if_req = 1'b1;
        tick();
        chk("refetch_addr", ram_addr, 32'h100);
        chk("refetch_c1_ready", 32'(if_ready), 32'd0);
        if_req = 1'b0;
        repeat (5) tick();
        chk("refetch_ready", 32'(if_ready), 32'd1);
        chk("refetch_data", if_data, 32'h4499_2211);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; all widths fixed as listed.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-004 if_req  in  1  instruction-fetch request, held high until if_ready.
REQ-005 if_addr  in  32  fetch byte address, always a 4-byte read.
REQ-006 if_ready  out  1  one-cycle pulse: fetch complete, if_data valid.
REQ-007 if_data  out  32  fetched word, little-endian.
REQ-008 mem_req  in  1  data-access request, held high until mem_ready.
REQ-009 mem_we  in  1  1=write, 0=read.
REQ-010 mem_addr  in  32  data byte address.
REQ-011 mem_len  in  2  access size: 00=1B, 01=2B, 11=4B; 10 is treated as 4B.
REQ-012 mem_wdata  in  32  write data; byte i = bits [8i+7:8i].
REQ-013 mem_ready  out  1  one-cycle pulse: data access complete.
REQ-014 mem_rdata  out  32  read data, zero-extended above mem_len bytes.
REQ-015 ram_addr  out  32  byte address to single-port byte RAM.
REQ-016 ram_we  out  1  RAM write enable.
REQ-017 ram_dout  out  8  RAM write byte.
REQ-018 ram_din  in  8  RAM read byte; valid the cycle after its address is driven.

Function
REQ-019 FSM states: IDLE, READ, WRITE, DONE; one transaction in flight at a time.
REQ-020 In IDLE, at an edge with any request high: latch addr/len/we/wdata and owner, clear byte counter cnt, go to READ or WRITE.
REQ-021 Simultaneous mem_req and if_req in IDLE: data port wins; fetch waits (IF starvation under continuous mem_req is permitted).
REQ-022 READ, n bytes: cycles C1..Cn drive ram_addr=base+cnt, ram_we=0; byte cnt is captured from ram_din in cycle C(cnt+2).
REQ-023 Read completion: ready pulse to owner in cycle Cn+2 (DONE) with full data on the data bus; a 4B fetch granted at edge E0 thus pulses if_ready in cycle C6.
REQ-024 WRITE, n bytes: cycles C1..Cn drive ram_we=1, ram_addr=base+cnt, ram_dout=wdata byte cnt; mem_ready pulses in Cn+1 with ram_we=0.
REQ-025 DONE lasts exactly one cycle then returns to IDLE; the next grant occurs at the following edge, giving one dead cycle between transactions.
REQ-026 Address arithmetic is modulo 2^32: base 0xFFFFFFFE, 4B accesses bytes FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-027 Requester inputs are sampled only at grant; changes or req deassertion mid-transaction are ignored and the transaction completes with its ready pulse.
REQ-028 if_data and mem_rdata hold their last completed value until the next completed read for that port.
REQ-029 Outside READ/WRITE address phases: ram_we=0, ram_addr=0, ram_dout=0.
REQ-030 if_ready and mem_ready are never high in the same cycle.

Reset
REQ-031 On reset: state=IDLE, cnt=0, if_ready=0, mem_ready=0, if_data=0, mem_rdata=0, ram_we=0, ram_addr=0, ram_dout=0, buffer invalid.
REQ-032 Reset mid-transaction aborts it with no ready pulse; ram_we=0 from the cycle after the reset edge.

Configuration
REQ-033 Macro FETCH_BUFFER_EN: when defined, a one-entry buffer holds the last fetched address and word plus a valid bit.
REQ-034 With FETCH_BUFFER_EN: if if_req is granted with if_addr equal to the buffered address and valid=1, no RAM cycles occur and if_ready pulses in C1 with the buffered word.
REQ-035 With FETCH_BUFFER_EN: any completed data write overlapping the buffered word clears valid.
REQ-036 Without FETCH_BUFFER_EN: no buffer logic exists; every fetch performs four RAM reads.

Verification
REQ-037 Fetch only, if_addr=0x100, RAM[100..103]=11,22,33,44 -> ram_addr 100..103 in C1..C4, if_ready in C6, if_data=0x44332211.
REQ-038 if_req and mem_req (read, 2B, addr 0x200) both high in IDLE -> data served first, mem_ready then later if_ready, never together.
REQ-039 mem write 4B 0xDEADBEEF to 0x10 -> ram_we=1 with bytes EF,BE,AD,DE at 0x10..0x13 in C1..C4, mem_ready in C5.
REQ-040 1B read at 0xFFFFFFFF holding 0x80 -> mem_rdata=0x00000080; 4B read at 0xFFFFFFFE wraps to 0x00000000.
REQ-041 reset=0 during C3 of a write -> ram_we=0 next cycle, no mem_ready, state IDLE.
REQ-042 FETCH_BUFFER_EN: repeated fetch of 0x100 -> if_ready in C1, no RAM access; after a write to 0x102, refetch uses RAM.
